// File: rtl/thdi_pkg.sv
// Shared constants, sample type and FSM states for the PISO frame transmitter.
// Imported by piso_frame_tx_if, piso_frame_buf and piso_frame_tx.
package thdi_pkg;
    localparam int DATA_W    = 16;
    localparam int N_SAMPLES = 32;
    localparam int CNT_W     = $clog2(N_SAMPLES);

    typedef logic signed [DATA_W-1:0] sample_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
endpackage

// File: rtl/piso_frame_tx_if.sv
// Load / stream handshake bundle of piso_frame_tx.
// master: frame source + sample sink side; slave: the transmitter.
interface piso_frame_tx_if;
    import thdi_pkg::*;

    logic                        load;
    logic [N_SAMPLES*DATA_W-1:0] d_in_flat;
    logic                        load_ready;
    logic                        out_valid;
    logic                        out_ready;
    sample_t                     d_out;
    logic                        first;
    logic                        last;
    logic                        done;

    modport master (
        output load, d_in_flat, out_ready,
        input  load_ready, out_valid, d_out, first, last, done
    );

    modport slave (
        input  load, d_in_flat, out_ready,
        output load_ready, out_valid, d_out, first, last, done
    );
endinterface

// File: rtl/piso_frame_buf.sv
// N x DATA_W frame register file: whole-frame write, indexed sample read.
// Ports: clk, we, wr_flat (frame in), rd_idx (sample index), rd_data.
module piso_frame_buf
    import thdi_pkg::*;
(
    input  logic                        clk,
    input  logic                        we,
    input  logic [N_SAMPLES*DATA_W-1:0] wr_flat,
    input  logic [CNT_W-1:0]            rd_idx,
    output sample_t                     rd_data
);
    logic [N_SAMPLES*DATA_W-1:0] mem_q;
    logic [N_SAMPLES*DATA_W-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d = wr_flat;
        end
    end

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[int'(rd_idx)*DATA_W +: DATA_W];
endmodule

// File: rtl/piso_frame_tx.sv
// Parallel-in serial-out frame transmitter with valid/ready output.
// Ports: clk, rst (sync, active-high), bus (piso_frame_tx_if.slave).
// PISO_SHADOW_BUF_EN adds a second bank for gap-free back-to-back frames.
module piso_frame_tx
    import thdi_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    piso_frame_tx_if.slave   bus
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic             xfer;
    logic             at_last;
    sample_t          rd_data;

    assign xfer    = (state_q == SHIFT) && bus.out_ready;
    assign at_last = (count_q == CNT_W'(N_SAMPLES-1));

`ifdef PISO_SHADOW_BUF_EN
    // Two banks in ping-pong: sel_q picks the bank being streamed,
    // the other one holds the queued (shadow) frame.
    logic    sel_q, sel_d;
    logic    shadow_full_q, shadow_full_d;
    logic    wr_act, wr_shd;
    logic    we0, we1;
    sample_t rd0, rd1;

    assign we0 = (wr_act && !sel_q) || (wr_shd && sel_q);
    assign we1 = (wr_act && sel_q) || (wr_shd && !sel_q);

    piso_frame_buf u_buf0 (
        .clk     (clk),
        .we      (we0),
        .wr_flat (bus.d_in_flat),
        .rd_idx  (count_q),
        .rd_data (rd0)
    );

    piso_frame_buf u_buf1 (
        .clk     (clk),
        .we      (we1),
        .wr_flat (bus.d_in_flat),
        .rd_idx  (count_q),
        .rd_data (rd1)
    );

    assign rd_data = sel_q ? rd1 : rd0;
    assign bus.load_ready = (state_q == IDLE) || !shadow_full_q;
`else
    logic wr_act;

    piso_frame_buf u_buf0 (
        .clk     (clk),
        .we      (wr_act),
        .wr_flat (bus.d_in_flat),
        .rd_idx  (count_q),
        .rd_data (rd_data)
    );

    assign bus.load_ready = (state_q == IDLE);
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        wr_act  = 1'b0;
`ifdef PISO_SHADOW_BUF_EN
        sel_d         = sel_q;
        shadow_full_d = shadow_full_q;
        wr_shd        = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.load) begin
                    wr_act  = 1'b1;
                    count_d = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (xfer && at_last) begin
                    done_d  = 1'b1;
                    count_d = '0;
                    state_d = IDLE;
`ifdef PISO_SHADOW_BUF_EN
                    // Swap to the queued frame, or take a load
                    // arriving right now straight into the idle bank.
                    if (shadow_full_q) begin
                        sel_d         = ~sel_q;
                        shadow_full_d = 1'b0;
                        state_d       = SHIFT;
                    end else if (bus.load) begin
                        wr_shd  = 1'b1;
                        sel_d   = ~sel_q;
                        state_d = SHIFT;
                    end
`endif
                end else begin
                    if (xfer) begin
                        count_d = count_q + CNT_W'(1);
                    end
`ifdef PISO_SHADOW_BUF_EN
                    if (bus.load && !shadow_full_q) begin
                        wr_shd        = 1'b1;
                        shadow_full_d = 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
`ifdef PISO_SHADOW_BUF_EN
            sel_q         <= 1'b0;
            shadow_full_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
`ifdef PISO_SHADOW_BUF_EN
            sel_q         <= sel_d;
            shadow_full_q <= shadow_full_d;
`endif
        end
    end

    assign bus.out_valid = (state_q == SHIFT);
    assign bus.d_out     = bus.out_valid ? rd_data : sample_t'(0);
    assign bus.first     = bus.out_valid && (count_q == '0);
    assign bus.last      = bus.out_valid && at_last;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_piso_frame_tx.sv
// Directed self-checking bench for piso_frame_tx.
// Covers streaming, backpressure, sign integrity, reset abort, mid-frame load.
module tb_piso_frame_tx;
    import thdi_pkg::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;
    int   n_done;

    logic [15:0] exp_frame [N_SAMPLES];
    logic [15:0] d_out_u;

    piso_frame_tx_if tx_if ();

    piso_frame_tx dut (
        .clk (clk),
        .rst (rst),
        .bus (tx_if.slave)
    );

    assign d_out_u = tx_if.d_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pack_frame();
        for (int k = 0; k < N_SAMPLES; k++)
            tx_if.d_in_flat[k*DATA_W +: DATA_W] = exp_frame[k];
    endtask

    task automatic set_seq(input int base);
        for (int k = 0; k < N_SAMPLES; k++)
            exp_frame[k] = 16'(base + k);
    endtask

    task automatic load_frame();
        pack_frame();
        tx_if.load = 1'b1;
        step();
        tx_if.load = 1'b0;
    endtask

    // Checks one frame against exp_frame; optional stall and load pulse.
    task automatic stream(input int stall_k, input int stall_len,
                          input int load_k);
        for (int k = 0; k < N_SAMPLES; k++) begin
            if (k == stall_k) begin
                tx_if.out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    step();
                    check("stall_dout", {16'h0, d_out_u}, {16'h0, exp_frame[k]});
                    check("stall_valid", {31'h0, tx_if.out_valid}, 32'd1);
                end
                tx_if.out_ready = 1'b1;
            end
            check("dout", {16'h0, d_out_u}, {16'h0, exp_frame[k]});
            check("valid", {31'h0, tx_if.out_valid}, 32'd1);
            check("first", {31'h0, tx_if.first}, {31'h0, k == 0});
            check("last", {31'h0, tx_if.last}, {31'h0, k == N_SAMPLES-1});
            if (k > 0)
                check("no_done", {31'h0, tx_if.done}, 32'd0);
            if (k == load_k)
                tx_if.load = 1'b1;
            step();
            tx_if.load = 1'b0;
        end
    endtask

    task automatic end_idle();
        check("done_hi", {31'h0, tx_if.done}, 32'd1);
        check("end_valid", {31'h0, tx_if.out_valid}, 32'd0);
        check("end_lrdy", {31'h0, tx_if.load_ready}, 32'd1);
        check("end_dout", {16'h0, d_out_u}, 32'd0);
        step();
        check("done_lo", {31'h0, tx_if.done}, 32'd0);
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1;
        tx_if.load = 1'b0;
        tx_if.out_ready = 1'b0;
        tx_if.d_in_flat = '0;
        step();
        step();
        rst = 1'b0;

        check("rst_valid", {31'h0, tx_if.out_valid}, 32'd0);
        check("rst_lrdy", {31'h0, tx_if.load_ready}, 32'd1);
        check("rst_dout", {16'h0, d_out_u}, 32'd0);
        check("rst_first", {31'h0, tx_if.first}, 32'd0);
        check("rst_last", {31'h0, tx_if.last}, 32'd0);
        check("rst_done", {31'h0, tx_if.done}, 32'd0);

        // Full frame 1..32 with continuous ready.
        tx_if.out_ready = 1'b1;
        set_seq(1);
        load_frame();
        check("busy_lrdy", {31'h0, tx_if.load_ready}, 32'd0);
        stream(-1, 0, -1);
        end_idle();

        // Backpressure: stall 3 cycles while d_out=6 (index 5).
        load_frame();
        stream(5, 3, -1);
        end_idle();

        // Sign integrity on extreme values.
        set_seq(0);
        exp_frame[0] = 16'h8000;
        exp_frame[1] = 16'hFFFF;
        exp_frame[2] = 16'h7FFF;
        load_frame();
        stream(-1, 0, -1);
        end_idle();

        // Reset at count=10, asserted together with load.
        set_seq(1);
        load_frame();
        for (int k = 0; k < 10; k++) step();
        check("pre_rst_dout", {16'h0, d_out_u}, 32'd11);
        rst = 1'b1;
        tx_if.load = 1'b1;
        step();
        rst = 1'b0;
        tx_if.load = 1'b0;
        check("abort_valid", {31'h0, tx_if.out_valid}, 32'd0);
        check("abort_dout", {16'h0, d_out_u}, 32'd0);
        check("abort_lrdy", {31'h0, tx_if.load_ready}, 32'd1);
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            if (tx_if.done || tx_if.out_valid) n_done++;
            step();
        end
        check("abort_quiet", n_done, 32'd0);
        set_seq(201);
        load_frame();
        stream(-1, 0, -1);
        end_idle();

`ifdef PISO_SHADOW_BUF_EN
        // Second frame queued at count=5 streams with zero gap.
        set_seq(1);
        load_frame();
        set_seq(101);
        pack_frame();
        set_seq(1);
        stream(-1, 0, 5);
        check("chain_done", {31'h0, tx_if.done}, 32'd1);
        set_seq(101);
        stream(-1, 0, -1);
        end_idle();
`else
        // Load pulse mid-frame is ignored.
        set_seq(1);
        load_frame();
        set_seq(301);
        pack_frame();
        set_seq(1);
        stream(-1, 0, 5);
        end_idle();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
